// File: rtl/spi_regmap_sequencer.sv
// SPI master that turns one register-map request into a single mode-0 frame
// {rw, addr, data}, MSB first, and reports completion with a one-cycle response.
module spi_regmap_sequencer #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 5,
    parameter int unsigned CS_GAP     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  sck,
    output logic                  sdo,
    input  logic                  sdi,
    output logic                  cs_n
);

    localparam int unsigned FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned BCNT_W  = $clog2(FRAME_W + 1);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]        GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(FRAME_W - 1);
    localparam logic [BCNT_W-1:0] ALL_BITS  = BCNT_W'(FRAME_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           div_cnt;
    logic [BCNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]   tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                 ready_en;
    logic                 accept;
    logic                 phase_end;
    logic                 last_bit;
    logic                 bits_done;
    logic                 cs_n_d;
    logic                 sck_d;
    logic                 sdo_d;
    logic                 rsp_valid_d;

    // Reads carry an all-zero data field.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic                  rw,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        return {rw, addr, (rw ? {DATA_WIDTH{1'b0}} : wdata)};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  bit_in
    );
        logic [DATA_WIDTH:0] ext;
        ext = {cur, bit_in};
        return ext[DATA_WIDTH-1:0];
    endfunction

    // ready_en keeps req_ready low until the first edge after reset release.
    assign req_ready = ready_en && (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign bits_done = (bit_cnt == ALL_BITS);

    always_comb begin
        phase_end = 1'b0;
        case (state)
            SETUP, HIGH, LOW: phase_end = (div_cnt == DIV_LAST);
            GAP:              phase_end = (div_cnt == GAP_LAST);
            default:          phase_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            state     <= state_next;
            cs_n      <= cs_n_d;
            sck       <= sck_d;
            sdo       <= sdo_d;
            rsp_valid <= rsp_valid_d;
            ready_en  <= 1'b1;
        end
    end

    // Pin values are registered together with the state so they change
    // exactly on phase boundaries and never glitch.
    always_comb begin
        state_next  = state;
        cs_n_d      = cs_n;
        sck_d       = sck;
        sdo_d       = sdo;
        rsp_valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                    cs_n_d     = 1'b0;
                    sck_d      = 1'b0;
                    sdo_d      = req_rw;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_next = HIGH;
                    sck_d      = 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_next = LOW;
                    sck_d      = 1'b0;
                    if (!last_bit) begin
                        sdo_d = tx_sh[FRAME_W-2];
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    if (bits_done) begin
                        state_next  = GAP;
                        cs_n_d      = 1'b1;
                        sdo_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_next = HIGH;
                        sck_d      = 1'b1;
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cs_n_d     = 1'b1;
                sck_d      = 1'b0;
                sdo_d      = 1'b0;
            end
        endcase
    end

    // Reset also clears the datapath so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rsp_rdata <= '0;
        end else begin
            if (state == IDLE || phase_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (accept) begin
                tx_sh   <= build_frame(req_rw, req_addr, req_wdata);
                bit_cnt <= '0;
            end

            // sdi is sampled on the edge that drops sck, a full half-period
            // after the slave was given the rising edge.
            if (state == HIGH && phase_end) begin
                rx_sh   <= shift_in(rx_sh, sdi);
                bit_cnt <= bit_cnt + BCNT_W'(1);
                if (!last_bit) begin
                    tx_sh <= tx_sh << 1;
                end
            end

            if (rsp_valid_d) begin
                rsp_rdata <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_spi_regmap_sequencer.sv
// Bench for spi_regmap_sequencer: SPI slave register-map model, frame monitor
// and a response scoreboard.
module tb_spi_regmap_sequencer;

    localparam int AW      = 7;
    localparam int DW      = 8;
    localparam int CLK_DIV = 5;
    localparam int CS_GAP  = 10;
    localparam int N       = 1 + AW + DW;
    localparam int CS_LOW  = (2 * N + 1) * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          sck;
    logic          sdo;
    logic          sdi;
    logic          cs_n;

    always #5 clk = ~clk;

    spi_regmap_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CLK_DIV   (CLK_DIV),
        .CS_GAP    (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .sck      (sck),
        .sdo      (sdo),
        .sdi      (sdi),
        .cs_n     (cs_n)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];
    logic [7:0] mem [0:127];

    // Slave register map: captures rw/addr, returns mem[addr] in the data field.
    bit            loopback = 1'b0;
    logic          slave_sdi = 1'b0;
    int            sl_cnt = 0;
    logic [N-1:0]  sl_shift = '0;
    logic [AW-1:0] sl_addr = '0;

    assign sdi = loopback ? sdo : slave_sdi;

    always @(negedge cs_n) begin
        sl_cnt    = 0;
        slave_sdi = 1'b0;
    end

    always @(posedge sck) begin
        if (cs_n === 1'b0) begin
            sl_shift = {sl_shift[N-2:0], sdo};
            sl_cnt++;
            if (sl_cnt == 1 + AW) sl_addr = sl_shift[AW-1:0];
            if (sl_cnt == N && !sl_shift[N-1]) mem[sl_shift[N-2:DW]] = sl_shift[DW-1:0];
        end
    end

    always @(negedge sck) begin
        #1;
        if (cs_n === 1'b0 && sl_cnt >= 1 + AW && sl_cnt < N)
            slave_sdi = mem[sl_addr][N-1-sl_cnt];
    end

    // Frame monitor, sampled on the falling clk edge.
    logic         cs_prev = 1'b1;
    logic         sck_prev = 1'b0;
    logic         hold_sdo = 1'b0;
    logic [N-1:0] cap = '0;
    logic [N-1:0] last_frame = '0;
    int rise_cnt = 0, cs_low_cnt = 0, cs_high_cnt = 0, since_rise = 0, unstable = 0;
    int last_rises = 0, last_cs_low = 0, last_cs_high = 0, last_unstable = 0;
    int last_acc_delay = -1, rsp_cnt = 0, excl_err = 0, idle_err = 0;

    always @(negedge clk) begin
        if (cs_n === 1'b0 && cs_prev === 1'b1) begin
            rise_cnt     = 0;
            cap          = '0;
            unstable     = 0;
            cs_low_cnt   = 0;
            last_cs_high = cs_high_cnt;
        end
        if (cs_n === 1'b1 && cs_prev === 1'b0) begin
            last_rises    = rise_cnt;
            last_frame    = cap;
            last_unstable = unstable;
            last_cs_low   = cs_low_cnt;
            cs_high_cnt   = 0;
            since_rise    = 0;
        end else begin
            since_rise++;
        end
        if (cs_n === 1'b0) cs_low_cnt++;
        else cs_high_cnt++;
        if (sck === 1'b1 && sck_prev !== 1'b1) begin
            rise_cnt++;
            cap      = {cap[N-2:0], sdo};
            hold_sdo = sdo;
        end else if (sck === 1'b1 && sdo !== hold_sdo) begin
            unstable++;
        end
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (busy === 1'b1 && req_ready === 1'b1) excl_err++;
        if (busy === 1'b0 && !rst && (cs_n !== 1'b1 || sck !== 1'b0 || sdo !== 1'b0)) idle_err++;
        if (req_valid && req_ready === 1'b1) last_acc_delay = since_rise;
        cs_prev  = cs_n;
        sck_prev = sck;
    end

    task automatic do_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output bit ok, output logic [DW-1:0] rd);
        int n;
        logic [DW-1:0] e;
        if (loopback) e = rw ? '0 : wd;
        else e = mem[addr];
        sb_q.push_back(e);
        ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (req_ready !== 1'b1) ok = 1'b0;
        @(negedge clk);
        // Scrambled inputs while busy must not affect the frame in flight.
        req_valid = 1'b0; req_rw = ~rw; req_addr = ~addr; req_wdata = ~wd;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        if (rsp_valid !== 1'b1) ok = 1'b0;
        rd = rsp_rdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (req_ready !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sck, sdo} !== 3'b100) begin
            errors++; $display("FAIL reset_pins: cs_n/sck/sdo got %b expected 100", {cs_n, sck, sdo});
        end
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: rsp_valid/busy/req_ready got %b expected 000", {rsp_valid, busy, req_ready});
        end
        checks++;
        if (rsp_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %b expected 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ready_after_release: ready/busy got %b%b expected 10", req_ready, busy);
        end
    endtask

    task automatic test_write_frame();
        bit ok;
        logic [DW-1:0] rd, e;
        logic [N-1:0] ef;
        int r0;
        r0 = rsp_cnt;
        ef = {1'b0, 7'h01, 8'hFF};
        do_txn(1'b0, 7'h01, 8'hFF, ok, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout: handshake got 0 expected 1"); end
        checks++;
        if (rd !== e) begin errors++; $display("FAIL write_rdata: got %h expected %h", rd, e); end
        checks++;
        if (last_rises != N) begin errors++; $display("FAIL write_sck_rises: got %0d expected %0d", last_rises, N); end
        checks++;
        if (last_frame !== ef) begin errors++; $display("FAIL write_sdo_bits: got %h expected %h", last_frame, ef); end
        checks++;
        if (last_cs_low != CS_LOW) begin errors++; $display("FAIL write_cs_low: got %0d expected %0d", last_cs_low, CS_LOW); end
        checks++;
        if (last_unstable != 0) begin errors++; $display("FAIL write_sdo_stable: got %0d changes expected 0", last_unstable); end
        checks++;
        if (rsp_cnt - r0 != 1) begin errors++; $display("FAIL write_rsp_pulse: got %0d cycles expected 1", rsp_cnt - r0); end
    endtask

    task automatic test_read();
        bit ok;
        logic [DW-1:0] rd, e;
        logic [N-1:0] ef;
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] want [3];
        addrs = '{7'h0C, 7'h0E, 7'h01};
        want  = '{8'h00, 8'hFF, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            ef = {1'b1, addrs[i], 8'h00};
            do_txn(1'b1, addrs[i], 8'h77, ok, rd);
            e = sb_q.pop_front();
            checks++;
            if (!ok || rd !== e || rd !== want[i]) begin
                errors++; $display("FAIL read_rdata[%0d]: got %h ok=%0d expected %h", i, rd, ok, want[i]);
            end
            checks++;
            if (last_frame !== ef) begin errors++; $display("FAIL read_sdo_bits[%0d]: got %h expected %h", i, last_frame, ef); end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [DW-1:0] rd, e;
        loopback = 1'b1;
        do_txn(1'b0, 7'h03, 8'hA5, ok, rd);
        e = sb_q.pop_front();
        loopback = 1'b0;
        checks++;
        if (!ok || rd !== e || rd !== 8'hA5) begin
            errors++; $display("FAIL loopback_rdata: got %h ok=%0d expected a5", rd, ok);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [DW-1:0] e;
        sb_q.push_back(mem[7'h10]);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h10; req_wdata = 8'h3C;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        req_rw = 1'b1; req_addr = 7'h10; req_wdata = 8'h00;
        sb_q.push_back(8'h3C);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
            errors++; $display("FAIL b2b_first: got %h valid=%b expected %h", rsp_rdata, rsp_valid, e);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
            errors++; $display("FAIL b2b_second: got %h valid=%b expected %h", rsp_rdata, rsp_valid, e);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (last_acc_delay != CS_GAP) begin
            errors++; $display("FAIL b2b_accept_delay: got %0d expected %0d", last_acc_delay, CS_GAP);
        end
        checks++;
        if (last_cs_high < CS_GAP) begin
            errors++; $display("FAIL b2b_cs_gap: got %0d expected >= %0d", last_cs_high, CS_GAP);
        end
    endtask

    task automatic test_reset_midframe();
        int n, rises, r0;
        logic prev;
        bit ok;
        logic [DW-1:0] rd, e;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h20; req_wdata = 8'h81;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 8 && n < 1000) begin
            @(negedge clk);
            if (sck === 1'b1 && !prev) rises++;
            prev = sck; n++;
        end
        checks++;
        if (rises != 8) begin errors++; $display("FAIL abort_reach_bit8: got %0d rises expected 8", rises); end
        r0 = rsp_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sck, busy} !== 3'b100) begin
            errors++; $display("FAIL abort_pins: cs_n/sck/busy got %b expected 100", {cs_n, sck, busy});
        end
        checks++;
        if (rsp_rdata !== '0) begin errors++; $display("FAIL abort_rdata: got %h expected 00", rsp_rdata); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_cnt != r0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", rsp_cnt - r0); end
        do_txn(1'b1, 7'h0E, 8'h00, ok, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok || rd !== e) begin errors++; $display("FAIL after_abort_rdata: got %h ok=%0d expected %h", rd, ok, e); end
        checks++;
        if (last_rises != N || last_cs_low != CS_LOW) begin
            errors++; $display("FAIL after_abort_frame: rises %0d cs_low %0d expected %0d %0d", last_rises, last_cs_low, N, CS_LOW);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[7'h0C] = 8'h00;
        mem[7'h0E] = 8'hFF;
        #1;
        test_reset();
        test_write_frame();
        test_read();
        test_loopback();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (excl_err != 0) begin errors++; $display("FAIL ready_busy_exclusive: got %0d overlaps expected 0", excl_err); end
        checks++;
        if (idle_err != 0) begin errors++; $display("FAIL idle_pins: got %0d bad cycles expected 0", idle_err); end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
